// File: rtl/seq_detect_ctrl_pkg.sv
// rtl/seq_detect_ctrl_pkg.sv - shared state encoding and default widths for the serial pattern detector
package seq_detect_ctrl_pkg;
   localparam int PAT_W_DEF = 8;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;
endpackage

// File: rtl/seq_match_core.sv
// rtl/seq_match_core.sv - bit history, valid-bit count and pattern compare
module seq_match_core
   import seq_detect_ctrl_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_bit,
   input  logic             i_bit_en,
   input  logic             i_clr,
   input  logic [3:0]       i_len,
   input  logic [PAT_W-1:0] i_pattern,
   input  logic             i_overlap,
   output logic             o_match
);
   localparam logic [3:0]       PAT_W_L = 4'(PAT_W);
   localparam logic [PAT_W-1:0] ONE     = {{(PAT_W-1){1'b0}}, 1'b1};

   logic [PAT_W-1:0] r_hist;
   logic [PAT_W-1:0] w_hist_next;
   logic [PAT_W-1:0] w_mask;
   logic [3:0]       r_vcnt;
   logic [3:0]       w_vcnt_next;

   // Compare sees the incoming bit already shifted in, so a match is flagged on the completing bit.
   always_comb begin
      w_hist_next = {r_hist[PAT_W-2:0], i_bit};
      w_vcnt_next = (r_vcnt == PAT_W_L) ? r_vcnt : r_vcnt + 4'd1;
      w_mask      = (ONE << i_len) - ONE;
      o_match     = i_bit_en && (w_vcnt_next >= i_len) &&
                    ((w_hist_next & w_mask) == (i_pattern & w_mask));
   end

   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) begin
         r_hist <= '0;
         r_vcnt <= '0;
      end else if (i_bit_en) begin
         r_hist <= w_hist_next;
         r_vcnt <= (o_match && !i_overlap) ? 4'd0 : w_vcnt_next;
      end
   end
endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - byte-fed serial pattern detector with match counter and threshold flag
module seq_detect_ctrl
   import seq_detect_ctrl_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [3:0]       cfg_len,
   input  logic             cfg_overlap,
   input  logic [CNT_W-1:0] cfg_thresh,
   input  logic             start,
   input  logic             stop,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             det_pulse,
   output logic [CNT_W-1:0] match_cnt,
   output logic             thresh_hit,
   output logic             busy,
   output logic             err_cfg
);
   localparam logic [3:0] PAT_W_L = 4'(PAT_W);

   state_t           r_state;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shreg;
   logic             r_stop_pend;
   logic [3:0]       r_len;
   logic [PAT_W-1:0] r_pat;
   logic             r_ovl;
   logic [CNT_W-1:0] r_thresh;
   logic [CNT_W-1:0] r_cnt;
   logic             r_det;
   logic             r_thresh_hit;
   logic             r_err;

   logic             w_legal;
   logic             w_accept;
   logic             w_hs;
   logic             w_stop_eff;
   logic             w_bit_en;
   logic             w_match;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_legal    = (cfg_len != 4'd0) && (cfg_len <= PAT_W_L);
   assign w_accept   = (r_state == ST_IDLE) && start && w_legal;
   assign in_ready   = (r_state == ST_WAIT) ||
                       ((r_state == ST_SHIFT) && (r_bit_idx == 3'd0) && !r_stop_pend);
   assign w_hs       = in_valid && in_ready;
   assign w_stop_eff = stop || r_stop_pend;
   assign w_bit_en   = (r_state == ST_SHIFT);
   assign w_cnt_inc  = r_cnt + CNT_W'(1);

   seq_match_core #(.PAT_W(PAT_W)) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_bit     (r_shreg[r_bit_idx]),
      .i_bit_en  (w_bit_en),
      .i_clr     (w_accept),
      .i_len     (r_len),
      .i_pattern (r_pat),
      .i_overlap (r_ovl),
      .o_match   (w_match)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_bit_idx    <= 3'd0;
         r_shreg      <= 8'd0;
         r_stop_pend  <= 1'b0;
         r_len        <= 4'd0;
         r_pat        <= '0;
         r_ovl        <= 1'b0;
         r_thresh     <= '0;
         r_cnt        <= '0;
         r_det        <= 1'b0;
         r_thresh_hit <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_det <= w_match;
         if (w_match && !(&r_cnt)) begin
            r_cnt <= w_cnt_inc;
            if ((r_thresh != '0) && (w_cnt_inc == r_thresh))
               r_thresh_hit <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               r_stop_pend <= 1'b0;
               if (start && w_legal) begin
                  r_len        <= cfg_len;
                  r_pat        <= cfg_pattern;
                  r_ovl        <= cfg_overlap;
                  r_thresh     <= cfg_thresh;
                  r_cnt        <= '0;
                  r_thresh_hit <= 1'b0;
                  r_err        <= 1'b0;
                  r_state      <= ST_WAIT;
               end else if (start) begin
                  r_err <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (w_hs) begin
                  r_shreg     <= in_data;
                  r_bit_idx   <= 3'd7;
                  r_stop_pend <= stop;
                  r_state     <= ST_SHIFT;
               end else if (stop) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               // A stop arriving on the bit-0 cycle still lets an accepted byte finish.
               if (r_bit_idx != 3'd0) begin
                  r_bit_idx <= r_bit_idx - 3'd1;
                  if (stop)
                     r_stop_pend <= 1'b1;
               end else if (w_hs) begin
                  r_shreg     <= in_data;
                  r_bit_idx   <= 3'd7;
                  r_stop_pend <= stop;
               end else if (w_stop_eff) begin
                  r_stop_pend <= 1'b0;
                  r_state     <= ST_IDLE;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign det_pulse  = r_det;
   assign match_cnt  = r_cnt;
   assign thresh_hit = r_thresh_hit;
   assign busy       = (r_state != ST_IDLE);
   assign err_cfg    = r_err;
endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter PAT_W, default 8, maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8, match counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cfg_pattern  input  PAT_W  pattern; bit [len-1] is the first serial bit expected, bit 0 the last.
REQ-006 cfg_len  input  4  pattern length; legal range 1..PAT_W.
REQ-007 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-008 cfg_thresh  input  CNT_W  match-count threshold; 0 disables thresh_hit.
REQ-009 start  input  1  pulse; latches cfg_*, clears history/count/flags, begins run.
REQ-010 stop  input  1  pulse; ends run after the current byte.
REQ-011 in_data  input  8  byte to scan, serialized MSB first.
REQ-012 in_valid / in_ready  input / output  1 each  byte handshake; transfer when both are high on a rising edge.
REQ-013 det_pulse  output  1  one-cycle pulse per detected match.
REQ-014 match_cnt  output  CNT_W  matches since start, saturating.
REQ-015 thresh_hit  output  1  sticky, set when match_cnt reaches cfg_thresh.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 err_cfg  output  1  sticky, set by start with illegal cfg_len.

Function
REQ-018 FSM states SHALL be IDLE, WAIT and SHIFT, with a 3-bit bit index in SHIFT.
REQ-019 In IDLE, start with a legal cfg_len SHALL go to WAIT, latch the config, and clear history, valid-bit count, match_cnt, thresh_hit and err_cfg.
REQ-020 In IDLE, start with cfg_len of 0 or greater than PAT_W SHALL set err_cfg and remain in IDLE.
REQ-021 In IDLE, stop SHALL be ignored.
REQ-022 Start SHALL be ignored while busy.
REQ-023 in_ready SHALL be high in WAIT, and in SHIFT when bit index = 0 with no stop pending; otherwise low.
REQ-024 A handshake SHALL load the byte and enter SHIFT at bit index 7; each SHIFT cycle SHALL shift one bit, 7 down to 0.
REQ-025 A handshake on the bit-0 cycle SHALL reload and stay in SHIFT, giving zero-bubble throughput of 8 cycles per byte.
REQ-026 At bit 0 with no new byte, the FSM SHALL go to WAIT; if a stop is pending, it SHALL go to IDLE instead.
REQ-027 Stop in WAIT SHALL go to IDLE next cycle; if a handshake occurs in the same cycle, the byte SHALL be fully scanned before IDLE.
REQ-028 Stop in SHIFT SHALL set stop-pending, cleared on entry to IDLE.
REQ-029 The history register SHALL shift each bit in and persist across bytes, so matches may span byte boundaries.
REQ-030 The valid-bit count SHALL increment per bit and saturate at PAT_W.
REQ-031 A match SHALL occur when valid count >= cfg_len and hist[len-1:0] == cfg_pattern[len-1:0], both including the current bit.
REQ-032 On a match, det_pulse SHALL be registered, asserting the cycle after the completing bit.
REQ-033 On a match, match_cnt SHALL increment, saturating at all-ones.
REQ-034 In non-overlap mode, a match SHALL clear the valid-bit count to 0.
REQ-035 thresh_hit SHALL set on the cycle match_cnt becomes equal to a nonzero cfg_thresh, and hold until the next accepted start.
REQ-036 match_cnt and thresh_hit SHALL hold their values in IDLE after a stop.

Reset
REQ-037 On rst_n low at a rising edge, the block SHALL enter IDLE with in_ready, det_pulse, match_cnt, thresh_hit, busy, err_cfg, history, counts and stop-pending all 0, including mid-byte.

Structure
REQ-038 A shared package SHALL hold the state enum and the PAT_W/CNT_W defaults.
REQ-039 Sub-module seq_match_core SHALL hold the history register, valid count and compare logic, with inputs bit, bit_en, clr, len, pattern, overlap and output match.

Verification
REQ-040 Scenario: pattern 11011, len 5, overlap 0, byte 0xDB -> one det_pulse, after bit 5; match_cnt = 1.
REQ-041 Scenario: same pattern with overlap 1, byte 0xDB -> pulses after bits 5 and 8; match_cnt = 2.
REQ-042 Scenario: pattern 1010, len 4, bytes 0x01 then 0x40 -> one pulse after the 3rd bit of the second byte (cross-boundary).
REQ-043 Scenario: in_valid held for 4 bytes -> in_ready high exactly on bit-0 cycles; 32 consecutive SHIFT cycles with no bubble.
REQ-044 Scenario: pattern 1, len 1, thresh 3, byte 0x07 -> thresh_hit rises with the 3rd pulse and stays high after stop.
REQ-045 Scenario: start with cfg_len 0 -> err_cfg = 1, busy = 0; rst_n low mid-SHIFT -> all outputs 0 at the next edge.
